// File: rtl/axi_wr_arbiter_pkg.sv
// axi_wr_arbiter_pkg: shared arbiter state encoding and AXI burst/response constants
package axi_wr_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} arb_state_e;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_wr_arbiter_if.sv
// axi_wr_arbiter_if: AXI write-path bundle (AW, W, B) for N lanes; bresp is shared by all lanes
// Modports: master drives aw*/w*/bready, slave drives awready/wready/bvalid/bresp
interface axi_wr_arbiter_if #(parameter int N = 1, parameter int AW = 32, parameter int DW = 64);
  logic [N*AW-1:0] awaddr;
  logic [N*8-1:0] awlen;
  logic [N*3-1:0] awsize;
  logic [N*2-1:0] awburst;
  logic [N-1:0] awvalid;
  logic [N-1:0] awready;
  logic [N*DW-1:0] wdata;
  logic [N*DW/8-1:0] wstrb;
  logic [N-1:0] wlast;
  logic [N-1:0] wvalid;
  logic [N-1:0] wready;
  logic [N-1:0] bvalid;
  logic [N-1:0] bready;
  logic [1:0] bresp;
  modport master (output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
                  input awready, wready, bvalid, bresp);
  modport slave (input awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
                 output awready, wready, bvalid, bresp);
endinterface

// File: rtl/axi_wr_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick after the stored pointer; pointer loads ptr_i on advance_i
// Ports: req_i requests, ptr_i new pointer value, advance_i load strobe, gnt_o one-hot winner
module rr_arbiter #(parameter int NM = 2, localparam int PW = $clog2(NM)) (
  input  logic          axi_aclk,
  input  logic          axi_aresetn,
  input  logic [NM-1:0] req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          advance_i,
  output logic [NM-1:0] gnt_o
);
  logic [PW-1:0] ptr_q;
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) ptr_q <= PW'(NM - 1);
    else if (advance_i) ptr_q <= ptr_i;
  end
  // Scan from farthest to nearest so the first requester after the pointer wins.
  always_comb begin
    gnt_o = '0;
    for (int k = NM; k >= 1; k--)
      if (req_i[(int'(ptr_q) + k) % NM]) gnt_o = NM'(1) << ((int'(ptr_q) + k) % NM);
  end
endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: shares one AXI write path between NM masters, grant locked from AW through B
// Ports: axi_aclk, axi_aresetn (sync active-low); s = NM-lane bundle from masters;
//        m = single-lane bundle to slave; grant one-hot owner; err_wlast sticky wlast mismatch
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(parameter int NM = 2, parameter int AW = 32, parameter int DW = 64) (
  input  logic            axi_aclk,
  input  logic            axi_aresetn,
  axi_wr_arbiter_if.slave  s,
  axi_wr_arbiter_if.master m,
  output logic [NM-1:0]   grant,
  output logic            err_wlast
);
  localparam int PW = $clog2(NM);
  arb_state_e state_q, state_d;
  logic [NM-1:0] grant_q, gnt;
  logic [PW-1:0] g_q, gidx;
  logic [7:0] beat_q, awlen_q;
  logic [AW-1:0] awaddr_q;
  logic [2:0] awsize_q;
  logic [1:0] awburst_q;
  logic err_q, wlast, w_hs, b_hs, start;
  rr_arbiter #(.NM(NM)) u_rr (
    .axi_aclk, .axi_aresetn,
    .req_i(s.awvalid & {NM{state_q == IDLE}}),
    .ptr_i(g_q), .advance_i(b_hs), .gnt_o(gnt)
  );
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NM; i++) if (gnt[i]) gidx = PW'(i);
  end
  assign start = |gnt;
  assign wlast = beat_q == 8'd0;
  assign w_hs = state_q == DATA && s.wvalid[g_q] && m.wready[0];
  assign b_hs = state_q == RESP && m.bvalid[0] && s.bready[g_q];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? ADDR : IDLE;
      ADDR: state_d = m.awready[0] ? DATA : ADDR;
      DATA: state_d = (w_hs && wlast) ? RESP : DATA;
      RESP: state_d = b_hs ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      g_q <= '0;
      beat_q <= '0;
      awaddr_q <= '0;
      awlen_q <= '0;
      awsize_q <= '0;
      awburst_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        grant_q <= gnt;
        g_q <= gidx;
        beat_q <= s.awlen[gidx*8 +: 8];
        awaddr_q <= s.awaddr[gidx*AW +: AW];
        awlen_q <= s.awlen[gidx*8 +: 8];
        awsize_q <= s.awsize[gidx*3 +: 3];
        awburst_q <= s.awburst[gidx*2 +: 2];
      end
      // Counter stops at zero; the zero-count handshake moves to RESP instead.
      if (w_hs && !wlast) beat_q <= beat_q - 8'd1;
      if (w_hs && s.wlast[g_q] != wlast) err_q <= 1'b1;
      if (b_hs) grant_q <= '0;
    end
  end
  assign grant = grant_q;
  assign err_wlast = err_q;
  assign s.awready = gnt;
  assign m.awaddr = awaddr_q;
  assign m.awlen = awlen_q;
  assign m.awsize = awsize_q;
  assign m.awburst = awburst_q;
  assign m.awvalid = state_q == ADDR;
  assign m.wvalid = state_q == DATA && s.wvalid[g_q];
  assign m.wdata = s.wdata[g_q*DW +: DW];
  assign m.wstrb = s.wstrb[g_q*(DW/8) +: DW/8];
  assign m.wlast = state_q == DATA && wlast;
  assign s.wready = state_q == DATA ? grant_q & {NM{m.wready[0]}} : '0;
  assign m.bready = state_q == RESP && s.bready[g_q];
  assign s.bvalid = state_q == RESP ? grant_q & {NM{m.bvalid[0]}} : '0;
  assign s.bresp = m.bresp;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed scoreboard bench for axi_wr_arbiter
module tb_axi_wr_arbiter;
  import axi_wr_arbiter_pkg::*;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  typedef struct packed {logic [7:0] m; logic [1:0] r;} b_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NM-1:0] grant;
  logic err;
  int total = 0;
  int bad = 0;
  int w;
  logic [AW+7:0] aw_q[$];
  logic [DW+DW/8:0] w_q[$];
  b_t b_q[$];
  logic [AW+7:0] ea;
  logic [DW+DW/8:0] ew;
  always #5 clk = ~clk;
  axi_wr_arbiter_if #(.N(NM), .AW(AW), .DW(DW)) mi();
  axi_wr_arbiter_if #(.N(1), .AW(AW), .DW(DW)) si();
  axi_wr_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
    .axi_aclk(clk), .axi_aresetn(rstn), .s(mi), .m(si), .grant(grant), .err_wlast(err)
  );
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic timeout(string tag);
    chk(tag, 128'd0, 128'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench stopped at %s", tag);
  endtask
  task automatic set_req(int i, logic [31:0] a, logic [7:0] len);
    mi.awaddr[i*AW +: AW] = a;
    mi.awlen[i*8 +: 8] = len;
    mi.awsize[i*3 +: 3] = 3'd3;
    mi.awburst[i*2 +: 2] = BURST_INCR;
    mi.awvalid[i] = 1'b1;
  endtask
  // Monitor: checks downstream traffic against the scoreboard queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (grant != '0) chk("aw_lock", 128'(mi.awready), 128'd0);
      if (si.awvalid[0] && si.awready[0]) begin
        if (aw_q.size() == 0) chk("aw_extra", 128'd1, 128'd0);
        else begin
          ea = aw_q.pop_front();
          chk("aw_fields", 128'({si.awaddr, si.awlen}), 128'(ea));
        end
      end
      if (si.wvalid[0]) begin
        if (w_q.size() == 0) chk("w_extra", 128'd1, 128'd0);
        else begin
          ew = w_q[0];
          chk("w_beat", 128'({si.wdata, si.wstrb, si.wlast}), 128'(ew));
          if (si.wready[0]) void'(w_q.pop_front());
        end
      end
      if (b_q.size() > 0) begin
        chk("b_route", 128'(mi.bvalid), si.bvalid[0] ? 128'(1) << b_q[0].m : 128'd0);
        if (si.bvalid[0]) begin
          chk("b_ready", 128'(si.bready), 128'd1);
          chk("b_resp", 128'(mi.bresp), 128'(b_q[0].r));
          if (si.bready[0]) void'(b_q.pop_front());
        end
      end
    end
  end
  task automatic xfer(int i, logic [31:0] a, logic [7:0] len, int bad_beat, bit tog, int bdly,
                      int abort_beat, int late, logic [1:0] resp, output int waited);
    int n;
    logic [DW-1:0] d;
    logic [DW/8-1:0] st;
    set_req(i, a, len);
    waited = 0;
    #1;
    while (!mi.awready[i]) begin
      if (waited == 30) timeout("aw_wait");
      waited++;
      @(posedge clk); #1;
    end
    aw_q.push_back({a, len});
    @(posedge clk); #1;
    mi.awvalid[i] = 1'b0;
    chk("grant_set", 128'(grant), 128'(1) << i);
    chk("m_awvalid", 128'(si.awvalid), 128'd1);
    chk("awready_pulse", 128'(mi.awready), 128'd0);
    for (int b = 0; b <= int'(len); b++) begin
      if (b == abort_beat) begin
        mi.wvalid[i] = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst_grant", 128'(grant), 128'd0);
        chk("rst_awvalid", 128'(si.awvalid), 128'd0);
        chk("rst_wvalid", 128'(si.wvalid), 128'd0);
        chk("rst_wready", 128'(mi.wready), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        w_q.delete();
        rstn = 1'b1;
        return;
      end
      if (b == 1 && late >= 0) set_req(late, a + 32'h100, 8'd0);
      d = {$urandom, $urandom};
      st = 8'($urandom);
      mi.wdata[i*DW +: DW] = d;
      mi.wstrb[i*8 +: 8] = st;
      mi.wlast[i] = (b == int'(len)) || (b == bad_beat);
      mi.wvalid[i] = 1'b1;
      w_q.push_back({d, st, b == int'(len)});
      n = 0;
      forever begin
        si.wready[0] = tog ? (n % 3 == 2) : 1'b1;
        #1;
        if (si.wvalid[0] && si.wready[0]) break;
        if (++n == 30) timeout("w_wait");
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (b == bad_beat) chk("err_set", 128'(err), 128'd1);
      if (b < int'(len)) chk("grant_hold", 128'(grant), 128'(1) << i);
    end
    mi.wvalid[i] = 1'b0;
    mi.wlast[i] = 1'b0;
    si.wready[0] = 1'b0;
    mi.bready[i] = 1'b1;
    b_q.push_back(b_t'{8'(i), resp});
    repeat (bdly) begin
      @(posedge clk); #1;
      chk("grant_resp", 128'(grant), 128'(1) << i);
    end
    si.bvalid[0] = 1'b1;
    si.bresp = resp;
    @(posedge clk); #1;
    si.bvalid[0] = 1'b0;
    mi.bready[i] = 1'b0;
    chk("grant_rel", 128'(grant), 128'd0);
    chk("b_done", 128'(b_q.size()), 128'd0);
  endtask
  initial begin
    mi.awaddr = '0; mi.awlen = '0; mi.awsize = '0; mi.awburst = '0; mi.awvalid = '0;
    mi.wdata = '0; mi.wstrb = '0; mi.wlast = '0; mi.wvalid = '0; mi.bready = '0;
    si.awready = 1'b1; si.wready = 1'b0; si.bvalid = 1'b0; si.bresp = RESP_OKAY;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant0", 128'(grant), 128'd0);
    chk("rst_err0", 128'(err), 128'd0);
    chk("rst_awvalid0", 128'(si.awvalid), 128'd0);
    chk("rst_wvalid0", 128'(si.wvalid), 128'd0);
    chk("rst_bready0", 128'(si.bready), 128'd0);
    chk("rst_awready0", 128'(mi.awready), 128'd0);
    chk("rst_bvalid0", 128'(mi.bvalid), 128'd0);
    rstn = 1'b1;
    // Both request together: M0, M1, M0.
    set_req(1, 32'h2000, 8'd1);
    xfer(0, 32'h1100, 8'd1, -1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("rr_first_m0", 128'(w), 128'd0);
    set_req(0, 32'h1200, 8'd2);
    xfer(1, 32'h2000, 8'd1, -1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("rr_then_m1", 128'(w), 128'd0);
    xfer(0, 32'h1200, 8'd2, -1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("rr_then_m0", 128'(w), 128'd0);
    // Single M0 write, four beats.
    xfer(0, 32'h1000, 8'd3, -1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("single_lat", 128'(w), 128'd0);
    // M1 requests while M0 is in DATA; it gets the next IDLE cycle.
    xfer(0, 32'h3000, 8'd3, -1, 1'b0, 1, -1, 1, RESP_OKAY, w);
    xfer(1, 32'h3100, 8'd0, -1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("late_m1_next", 128'(w), 128'd0);
    // Single beat with stalls and delayed response.
    xfer(0, 32'h4000, 8'd0, -1, 1'b1, 5, -1, -1, RESP_SLVERR, w);
    // s_wlast raised on beat 2 of 4.
    chk("err_before", 128'(err), 128'd0);
    xfer(0, 32'h5000, 8'd3, 1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("err_after", 128'(err), 128'd1);
    xfer(1, 32'h5100, 8'd1, -1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("err_sticky", 128'(err), 128'd1);
    // Reset during beat 2, then a fresh M0 request.
    xfer(0, 32'h6000, 8'd3, -1, 1'b0, 0, 1, -1, RESP_OKAY, w);
    xfer(0, 32'h7000, 8'd1, -1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("post_rst_grant", 128'(w), 128'd0);
    chk("post_rst_err", 128'(err), 128'd0);
    // Longest burst: 256 beats.
    xfer(1, 32'h8000, 8'd255, -1, 1'b0, 0, -1, -1, RESP_OKAY, w);
    chk("long_queue", 128'(w_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
